// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings and default sizes for the cache/memory arbiter slice.
package cache_pkg;

  localparam int ADDR_W_DEF  = 16;
  localparam int DATA_W_DEF  = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int OFF_W       = $clog2(BLOCK_WORDS * 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2
  } state_t;

endpackage

// File: rtl/cache_mem_arbiter_fill_word_counter.sv
// Per-fill word counter: enable-gated increment, synchronous clear, and a
// terminal flag that holds the count at TERM instead of wrapping.
module fill_word_counter #(
  parameter int CNT_W = 4,
  parameter int TERM  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  assign done = (cnt == CNT_W'(TERM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between I-cache and D-cache block fills plus D-cache
// write-through stores. Optional macro ARB_ROUND_ROBIN_EN alternates read grants.
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W      = cache_pkg::ADDR_W_DEF,
  parameter int DATA_W      = cache_pkg::DATA_W_DEF,
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int OFF_W       = cache_pkg::OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_wr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic [DATA_W-1:0] i_data,
  output logic              i_data_valid,
  output logic [DATA_W-1:0] d_data,
  output logic              d_data_valid,
  output logic              d_wr_ack
);

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [OFF_W-1:0]  issue_cnt;
  logic [OFF_W-1:0]  ret_cnt;
  logic              issue_done;
  logic              ret_done;
  logic              filling;
  logic              wr_req;
  logic              rd_d;
  logic              pick_d;
  logic              ret_last;
  logic              unused_bits;

  assign filling  = (state != IDLE);
  assign wr_req   = d_req & d_wr;
  assign rd_d     = d_req & ~d_wr;
  assign ret_last = (ret_cnt == OFF_W'(BLOCK_WORDS - 1));

  // Block offset bits of the request addresses are discarded by the fill.
  assign unused_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    block_base = {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction

  function automatic logic [ADDR_W-1:0] word_offset(input logic [OFF_W-1:0] n);
    word_offset = ADDR_W'({n, 1'b0});
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = D-cache was granted most recently
  assign pick_d = rd_d & (~i_req | ~last_grant);
`else
  assign pick_d = rd_d;
`endif

  fill_word_counter #(.CNT_W(OFF_W), .TERM(BLOCK_WORDS)) u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (~filling),
    .en   (filling),
    .cnt  (issue_cnt),
    .done (issue_done)
  );

  fill_word_counter #(.CNT_W(OFF_W), .TERM(BLOCK_WORDS)) u_ret_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (~filling),
    .en   (filling & mem_rdata_valid),
    .cnt  (ret_cnt),
    .done (ret_done)
  );

  // Writes hold the FSM in IDLE; a fill ends on the edge after its last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      base  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!wr_req) begin
            if (pick_d) begin
              state <= FILL_D;
              base  <= block_base(d_addr);
`ifdef ARB_ROUND_ROBIN_EN
              last_grant <= 1'b1;
`endif
            end else if (i_req) begin
              state <= FILL_I;
              base  <= block_base(i_addr);
`ifdef ARB_ROUND_ROBIN_EN
              last_grant <= 1'b0;
`endif
            end
          end
        end
        FILL_I, FILL_D: begin
          if (mem_rdata_valid && ret_last) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_grant = (state == FILL_I);
  assign d_grant = (state == FILL_D);

  always_comb begin
    mem_addr     = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
    d_wr_ack     = 1'b0;
    i_data       = '0;
    i_data_valid = 1'b0;
    d_data       = '0;
    d_data_valid = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          mem_enable = 1'b1;
          mem_wr     = 1'b1;
          mem_addr   = d_addr;
          mem_wdata  = d_wdata;
          d_wr_ack   = 1'b1;
        end
      end
      FILL_I, FILL_D: begin
        if (!issue_done) begin
          mem_enable = 1'b1;
          mem_addr   = base | word_offset(issue_cnt);
        end
        if (mem_rdata_valid && !ret_done) begin
          if (state == FILL_I) begin
            i_data       = mem_rdata;
            i_data_valid = 1'b1;
          end else begin
            d_data       = mem_rdata;
            d_data_valid = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed plus randomized bench for cache_mem_arbiter with a behavioural
// memory and a fill-level reference model.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, mem_rdata_valid;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [15:0] mem_addr, mem_wdata, i_data, d_data;
  logic        mem_enable, mem_wr, i_grant, d_grant;
  logic        i_data_valid, d_data_valid, d_wr_ack;

  always #5 clk = ~clk;

  cache_mem_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .d_req           (d_req),
    .d_addr          (d_addr),
    .d_wr            (d_wr),
    .d_wdata         (d_wdata),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_addr        (mem_addr),
    .mem_enable      (mem_enable),
    .mem_wr          (mem_wr),
    .mem_wdata       (mem_wdata),
    .i_grant         (i_grant),
    .d_grant         (d_grant),
    .i_data          (i_data),
    .i_data_valid    (i_data_valid),
    .d_data          (d_data),
    .d_data_valid    (d_data_valid),
    .d_wr_ack        (d_wr_ack)
  );

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents are a fixed scramble of the word address.
  function automatic logic [15:0] memf(input logic [15:0] a);
    memf = {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  typedef struct {
    int          due;
    logic [15:0] data;
  } ret_t;

  ret_t pend[$];
  int   cyc       = 0;
  int   last_due  = 0;
  int   lat_fixed = 0;
  bit   last_d    = 1'b0;

  // Behavioural memory: in-order returns, 1..5 cycle latency per read.
  always @(negedge clk) begin
    int d;
    if (mem_enable === 1'b1 && mem_wr === 1'b0) begin
      d = cyc + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5)));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{due: d, data: memf(mem_addr)});
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = pend[0].data;
      void'(pend.pop_front());
    end else begin
      mem_rdata_valid = 1'b0;
      mem_rdata       = 16'($urandom);
    end
  end

  task automatic check_quiet(input string tag);
    check({tag, "_grants"}, {i_grant, d_grant}, 0);
    check({tag, "_valids"}, {i_data_valid, d_data_valid}, 0);
    check({tag, "_mem"}, {mem_enable, mem_wr, d_wr_ack}, 0);
  endtask

  // Expected fill: 8 consecutive reads from the block base, words returned
  // in order to the granted side only.
  task automatic run_fill(input bit side_d, input logic [15:0] req_addr,
                          input int drop_at, input int stop_ret);
    logic [15:0] base;
    int issued, ret, n;
    base   = {req_addr[15:4], 4'h0};
    issued = 0;
    ret    = 0;
    n      = 0;
    last_d = side_d;
    while (ret < stop_ret && n < 80) begin
      @(negedge clk);
      n++;
      check("own_grant", side_d ? d_grant : i_grant, 1);
      check("other_grant", side_d ? i_grant : d_grant, 0);
      check("fill_no_wr", {mem_wr, d_wr_ack}, 0);
      if (issued < 8) begin
        check("rd_en", mem_enable, 1);
        check("rd_addr", mem_addr, base + 16'(2 * issued));
        issued++;
        if (issued == drop_at) begin
          if (side_d) d_req = 1'b0;
          else i_req = 1'b0;
        end
      end else begin
        check("rd_stop", mem_enable, 0);
      end
      if (mem_rdata_valid === 1'b1) begin
        check("own_valid", side_d ? d_data_valid : i_data_valid, 1);
        check("own_data", side_d ? d_data : i_data, memf(base + 16'(2 * ret)));
        ret++;
      end else begin
        check("own_valid_idle", side_d ? d_data_valid : i_data_valid, 0);
      end
      check("other_valid", side_d ? i_data_valid : d_data_valid, 0);
    end
    if (ret < stop_ret) check("fill_timeout", ret, stop_ret);
  endtask

  task automatic idle_check(input bit wr);
    @(negedge clk);
    check("idle_grants", {i_grant, d_grant}, 0);
    check("idle_valids", {i_data_valid, d_data_valid}, 0);
    check("idle_en", mem_enable, wr);
    check("idle_ack", d_wr_ack, wr);
  endtask

  task automatic start_req(input bit side_d, input logic [15:0] a);
    @(posedge clk);
    #2;
    if (side_d) begin
      d_req = 1'b1; d_wr = 1'b0; d_addr = a;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    @(posedge clk);
  endtask

  task automatic both_fill(input logic [15:0] ad, input logic [15:0] ai,
                           input int drop_a, input int drop_b);
    bit first_d;
    @(posedge clk);
    #2;
    d_req = 1'b1; d_wr = 1'b0; d_addr = ad;
    i_req = 1'b1; i_addr = ai;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = !last_d;
`else
    first_d = 1'b1;
`endif
    @(posedge clk);
    run_fill(first_d, first_d ? ad : ai, drop_a, 8);
    idle_check(1'b0);
    @(posedge clk);
    run_fill(!first_d, first_d ? ai : ad, drop_b, 8);
    idle_check(1'b0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] w);
    @(posedge clk);
    #2;
    d_req = 1'b1; d_wr = 1'b1; d_addr = a; d_wdata = w;
    #1;
    check("wr_en", {mem_enable, mem_wr, d_wr_ack}, 3'b111);
    check("wr_addr", mem_addr, a);
    check("wr_data", mem_wdata, w);
    check("wr_grants", {i_grant, d_grant}, 0);
    @(posedge clk);
    #2;
    d_req = 1'b0; d_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a1, a2;
    rst = 1'b1;
    i_req = 0; d_req = 0; d_wr = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_rdata_valid = 0;

    @(negedge clk);
    check_quiet("reset");
    check("reset_addr", mem_addr, 0);
    check("reset_data", {i_data, d_data}, 0);
    check("reset_wdata", mem_wdata, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // I-cache fill at latency 4
    lat_fixed = 4;
    start_req(1'b0, 16'h1236);
    run_fill(1'b0, 16'h1236, 1, 8);
    idle_check(1'b0);
    lat_fixed = 0;

    // simultaneous D and I requests
    both_fill(16'h2000, 16'h4000, 1, 1);

    // write in IDLE, then the same write stalled by an I fill
    do_write(16'h0010, 16'hBEEF);
    @(posedge clk);
    #2 i_req = 1'b1; i_addr = 16'h0100;
    @(posedge clk);
    #2 d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF;
    run_fill(1'b0, 16'h0100, 1, 8);
    idle_check(1'b1);
    check("stall_wr_addr", mem_addr, 16'h0010);
    check("stall_wr_data", mem_wdata, 16'hBEEF);
    @(posedge clk);
    #2 d_req = 1'b0; d_wr = 1'b0;

    // reset after the 3rd returned word
    start_req(1'b1, 16'h3456);
    run_fill(1'b1, 16'h3456, 1, 3);
    rst = 1'b1;
    last_d = 1'b0;
    #1;
    check_quiet("rst_mid");
    check("rst_mid_addr", mem_addr, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    n = 0;
    while ((pend.size() > 0 || n < 4) && n < 40) begin
      @(negedge clk);
      n++;
      check_quiet("late_ret");
    end
    if (pend.size() > 0) check("late_ret_timeout", pend.size(), 0);

    // stray valid in IDLE
    @(posedge clk);
    #2;
    pend.push_back('{due: cyc + 1, data: 16'hDEAD});
    if (last_due < cyc + 1) last_due = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    check_quiet("stray");

    // requester drops after 2 issued reads
    start_req(1'b0, 16'h0A5C);
    run_fill(1'b0, 16'h0A5C, 2, 8);
    idle_check(1'b0);

    // randomized mix of fills, contended fills and writes
    for (int k = 0; k < 10; k++) begin
      a1 = 16'($urandom);
      a2 = 16'($urandom);
      case ($urandom_range(0, 2))
        0: begin
          if ($urandom_range(0, 1) == 1) begin
            start_req(1'b1, a1);
            run_fill(1'b1, a1, int'($urandom_range(1, 8)), 8);
          end else begin
            start_req(1'b0, a1);
            run_fill(1'b0, a1, int'($urandom_range(1, 8)), 8);
          end
          idle_check(1'b0);
        end
        1: both_fill(a1, a2, int'($urandom_range(1, 8)), int'($urandom_range(1, 8)));
        default: do_write(a1, a2);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Sits between the I-cache and D-cache fill state machines and the single shared main-memory port.
- Grants the memory to one requester for an entire 8-word block fill.
- Issues one read per cycle to memory and routes the returned words, with their valid strobe, back to the granted requester only.
- Also forwards single-word D-cache write-through stores when no fill is in progress.

Parameters:
- ADDR_W, 16, address width (byte address).
- DATA_W, 16, memory word width.
- BLOCK_WORDS, 8, words per cache block; power of 2; the address steps by 2 per word.
- OFF_W, 4, block offset bits, equal to log2(BLOCK_WORDS*2).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- i_req  in  1  I-cache fill request (miss pending).
- i_addr  in  ADDR_W  I-cache miss address.
- d_req  in  1  D-cache request (fill or write).
- d_addr  in  ADDR_W  D-cache miss or write address.
- d_wr  in  1  qualifies d_req as a single-word write.
- d_wdata  in  DATA_W  write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_rdata_valid  in  1  memory read data valid.
- mem_addr  out  ADDR_W  memory address.
- mem_enable  out  1  memory access strobe.
- mem_wr  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- i_grant  out  1  I-cache fill in progress.
- d_grant  out  1  D-cache fill in progress.
- i_data  out  DATA_W  fill data to the I-cache.
- i_data_valid  out  1  fill data valid to the I-cache.
- d_data  out  DATA_W  fill data to the D-cache.
- d_data_valid  out  1  fill data valid to the D-cache.
- d_wr_ack  out  1  write accepted this cycle.

Behaviour:
- Reset values:
  - All outputs are 0; state is IDLE; issue_cnt and ret_cnt are 0.
  - The latched base address is 0.
- States: IDLE, FILL_I, FILL_D (2-bit encoding).
- IDLE, evaluated in priority order:
  - d_req & d_wr: drive mem_enable=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata and d_wr_ack=1 combinationally in the same cycle. Stay in IDLE.
  - d_req & ~d_wr: latch base={d_addr[15:OFF_W], 0}, go to FILL_D.
  - i_req: latch base={i_addr[15:OFF_W], 0}, go to FILL_I.
  - D has fixed priority over I unless the optional feature below is compiled in.
- FILL_x:
  - While issue_cnt < BLOCK_WORDS: mem_enable=1, mem_wr=0, mem_addr=base | (issue_cnt<<1); issue_cnt increments every cycle.
  - The first read issues the cycle after the state is entered.
- Return routing:
  - Each mem_rdata_valid in FILL_x drives x_data=mem_rdata and x_data_valid=1 combinationally in the same cycle. ret_cnt increments.
  - The other requester's valid stays 0.
- Fill completion:
  - When ret_cnt reaches BLOCK_WORDS-1 and a valid arrives, return to IDLE on the next edge.
  - x_grant is 1 for the whole FILL_x state.
- Memory latency is arbitrary (≥1 cycle). The arbiter keeps no latency counter and relies only on mem_rdata_valid.
- Boundary conditions:
  - d_wr during any FILL: d_wr_ack=0 and the write stalls until IDLE.
  - A requester dropping req mid-fill is ignored; the fill completes.
  - mem_rdata_valid in IDLE is dropped.
  - Counter wrap: issue_cnt is OFF_W-bit wide and saturates at BLOCK_WORDS (no wrap).
  - d_req and i_req asserted in the same IDLE cycle: D wins. I is served after D's fill if i_req is still high.
  - rst asserted mid-fill: immediately IDLE. Late returns arriving after reset deasserts are dropped.
  - The same requester re-requesting immediately after completion is granted with no idle bubble beyond the single IDLE cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant flop, reset to I.
  - On simultaneous read requests, the requester not granted last wins.
  - Writes still take precedence in IDLE.
- Undefined: fixed D-over-I priority; last_grant does not exist.

Decomposition:
- Package cache_pkg holds:
  - the state encodings IDLE/FILL_I/FILL_D;
  - BLOCK_WORDS and OFF_W;
  - the ADDR_W/DATA_W defaults.
- One natural sub-module, fill_word_counter, instantiated twice (issue and return):
  - enable-gated incrementer with a synchronous clear;
  - terminal-count flag at BLOCK_WORDS.

Test Plan:
1. i_req=1, i_addr=0x1236, memory latency 4: reads to 0x1230, 0x1232 … 0x123E on consecutive cycles. 8 i_data_valid pulses, d_data_valid=0 throughout, i_grant drops after the 8th word.
2. d_req=1 and i_req=1 in the same cycle, addresses 0x2000/0x4000: D fills 0x2000–0x200E first, then I fills 0x4000–0x400E. With ARB_ROUND_ROBIN_EN and last_grant=D, I goes first.
3. d_req=1, d_wr=1, d_addr=0x0010, d_wdata=0xBEEF in IDLE: same cycle mem_wr=1, mem_addr=0x0010, mem_wdata=0xBEEF, d_wr_ack=1. The same write during FILL_I gives d_wr_ack=0 until IDLE.
4. rst pulsed after the 3rd returned word, memory still returning: all outputs 0 at once. The remaining valids produce no x_data_valid.
5. Stray mem_rdata_valid=1 in IDLE: no data_valid pulse; state and counters unchanged.
6. i_req deasserted after 2 issued reads: all 8 reads issue and all 8 words return, then IDLE.
